// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_pkg: shared types and widths for the multi-port SDRAM front end.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_REFRESH
  } state_t;

  localparam int SDR_ADDR_W = 23;
  localparam int SDR_DATA_W = 8;

  // Width of a port index; a single port still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client-side request bus plus driver-side command bus of the SDRAM front end.
// master: the arbiter. slave: the clients/driver environment.
interface sdram_port_arbiter_if #(
  parameter int NPORTS = 3,
  parameter int ADDR_W = 21
);
  import sdram_pkg::*;

  logic [NPORTS-1:0]            p_rd;
  logic [NPORTS-1:0]            p_wr;
  logic [NPORTS*ADDR_W-1:0]     p_addr;
  logic [NPORTS*SDR_DATA_W-1:0] p_din;
  logic [NPORTS*SDR_DATA_W-1:0] p_dout;
  logic [NPORTS-1:0]            p_ack;
  logic                         rfsh;
  logic                         busy;
  logic [SDR_ADDR_W-1:0]        sdr_addr;
  logic [SDR_DATA_W-1:0]        sdr_din;
  logic                         sdr_rd;
  logic                         sdr_wr;
  logic                         sdr_refresh;
  logic [SDR_DATA_W-1:0]        sdr_dout;
  logic                         sdr_busy;
  logic                         sdr_data_ready;

  modport master (
    input  p_rd, p_wr, p_addr, p_din, rfsh, sdr_dout, sdr_busy, sdr_data_ready,
    output p_dout, p_ack, busy, sdr_addr, sdr_din, sdr_rd, sdr_wr, sdr_refresh
  );

  modport slave (
    output p_rd, p_wr, p_addr, p_din, rfsh, sdr_dout, sdr_busy, sdr_data_ready,
    input  p_dout, p_ack, busy, sdr_addr, sdr_din, sdr_rd, sdr_wr, sdr_refresh
  );

endinterface

// File: rtl/sdram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Scans from last_grant+1 and
// wraps; the grant pointer itself lives in the parent.
module rr_arbiter
  import sdram_pkg::*;
#(
  parameter int NPORTS = 3
) (
  input  logic [NPORTS-1:0]         i_req,
  input  logic [idx_w(NPORTS)-1:0]  i_last_grant,
  output logic                      o_grant_valid,
  output logic [idx_w(NPORTS)-1:0]  o_grant
);

  localparam int GW = idx_w(NPORTS);

  function automatic logic [GW-1:0] wrap(input int v);
    return GW'(v % NPORTS);
  endfunction

  // First requester after the last grant wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant       = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      if (!o_grant_valid && i_req[wrap(int'(i_last_grant) + i)]) begin
        o_grant_valid = 1'b1;
        o_grant       = wrap(int'(i_last_grant) + i);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin multi-client front end to the byte-wide
// SDRAM driver; one driver command at a time, refresh always first.
// Optional: SDRAM_AUTO_REFRESH_EN adds an internal refresh interval counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_INIT    | waiting for the driver to finish its power-up (sdr_busy low)
// ST_IDLE    | picking refresh or the next client
// ST_READ    | read strobe issued, waiting for sdr_data_ready
// ST_WRITE   | write strobe issued, waiting for sdr_busy to drop
// ST_REFRESH | refresh strobe issued, waiting for sdr_busy to drop
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int NPORTS           = 3,
  parameter int ADDR_W           = 21,
  parameter int REFRESH_INTERVAL = 780
) (
  input logic                  clk,
  input logic                  resetn,
  sdram_port_arbiter_if.master bus
);

  localparam int GW = idx_w(NPORTS);

  state_t                       r_state, w_state_nxt;
  logic [GW-1:0]                r_grant, r_last_grant, w_grant;
  logic                         w_grant_valid;
  logic [NPORTS-1:0]            w_req;
  logic                         r_rfsh_pend, w_rfsh_expire;
  logic                         w_start_rd, w_start_wr, w_start_rf;
  logic                         w_rd_done, w_wr_done;
  logic                         r_sdr_rd, r_sdr_wr, r_sdr_refresh;
  logic [SDR_ADDR_W-1:0]        r_sdr_addr;
  logic [SDR_DATA_W-1:0]        r_sdr_din;
  logic [NPORTS-1:0]            r_p_ack;
  logic [NPORTS*SDR_DATA_W-1:0] r_p_dout;

  // A port being acked this cycle still holds its request; keep it out of
  // the pick so it is not served twice.
  assign w_req = (bus.p_rd | bus.p_wr) & ~r_p_ack;

  rr_arbiter #(.NPORTS(NPORTS)) u_rr_arbiter (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant_valid(w_grant_valid),
    .o_grant      (w_grant)
  );

  // Next state and one-cycle start/done events.
  always_comb begin
    w_state_nxt = r_state;
    w_start_rd  = 1'b0;
    w_start_wr  = 1'b0;
    w_start_rf  = 1'b0;
    w_rd_done   = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      ST_INIT: if (!bus.sdr_busy) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (r_rfsh_pend) begin
          w_state_nxt = ST_REFRESH;
          w_start_rf  = 1'b1;
        end else if (w_grant_valid) begin
          if (bus.p_wr[w_grant]) begin
            w_state_nxt = ST_WRITE;
            w_start_wr  = 1'b1;
          end else begin
            w_state_nxt = ST_READ;
            w_start_rd  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (bus.sdr_data_ready) begin
          w_state_nxt = ST_IDLE;
          w_rd_done   = 1'b1;
        end
      end
      // The strobe cycle is the guard: the driver has not raised busy yet.
      ST_WRITE: begin
        if (!r_sdr_wr && !bus.sdr_busy) begin
          w_state_nxt = ST_IDLE;
          w_wr_done   = 1'b1;
        end
      end
      ST_REFRESH: if (!r_sdr_refresh && !bus.sdr_busy) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_INIT;
    else         r_state <= w_state_nxt;
  end

  // Command strobes, latched command, grant pointer and client responses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sdr_rd      <= 1'b0;
      r_sdr_wr      <= 1'b0;
      r_sdr_refresh <= 1'b0;
      r_sdr_addr    <= '0;
      r_sdr_din     <= '0;
      r_grant       <= '0;
      r_last_grant  <= GW'(NPORTS - 1);
      r_p_ack       <= '0;
      r_p_dout      <= '0;
    end else begin
      r_sdr_rd      <= w_start_rd;
      r_sdr_wr      <= w_start_wr;
      r_sdr_refresh <= w_start_rf;
      r_p_ack       <= '0;
      if (w_start_rd || w_start_wr) begin
        r_sdr_addr   <= SDR_ADDR_W'(bus.p_addr[w_grant*ADDR_W +: ADDR_W]);
        r_sdr_din    <= bus.p_din[w_grant*SDR_DATA_W +: SDR_DATA_W];
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
      end
      if (w_rd_done || w_wr_done) r_p_ack[r_grant] <= 1'b1;
      if (w_rd_done) r_p_dout[r_grant*SDR_DATA_W +: SDR_DATA_W] <= bus.sdr_dout;
    end
  end

`ifdef SDRAM_AUTO_REFRESH_EN
  localparam int CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  logic [CW-1:0] r_rfsh_cnt;

  // Free-running interval down-counter, runs in every state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               r_rfsh_cnt <= CW'(REFRESH_INTERVAL - 1);
    else if (r_rfsh_cnt == '0) r_rfsh_cnt <= CW'(REFRESH_INTERVAL - 1);
    else                       r_rfsh_cnt <= r_rfsh_cnt - 1'b1;
  end

  assign w_rfsh_expire = (r_rfsh_cnt == '0);
`else
  assign w_rfsh_expire = 1'b0;
`endif

  // Single pending-refresh flag; a new request in the issue cycle re-arms it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rfsh_pend <= 1'b0;
    else         r_rfsh_pend <= bus.rfsh | w_rfsh_expire | (r_rfsh_pend & ~w_start_rf);
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.sdr_rd      = r_sdr_rd;
  assign bus.sdr_wr      = r_sdr_wr;
  assign bus.sdr_refresh = r_sdr_refresh;
  assign bus.sdr_addr    = r_sdr_addr;
  assign bus.sdr_din     = r_sdr_din;
  assign bus.p_ack       = r_p_ack;
  assign bus.p_dout      = r_p_dout;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small behavioural driver model.
module tb_sdram_port_arbiter;
  import sdram_pkg::*;

  localparam int NP     = 3;
  localparam int AW     = 21;
  localparam int RI     = 16;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.NPORTS(NP), .ADDR_W(AW)) bus ();

  sdram_port_arbiter #(.NPORTS(NP), .ADDR_W(AW), .REFRESH_INTERVAL(RI)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // driver model: read returns data after a fixed latency, write/refresh hold busy
  logic       force_busy = 1'b1;
  int         drv_cnt = 0;
  logic       drv_is_rd = 1'b0;
  logic       drv_ready = 1'b0;
  logic [7:0] drv_data = 8'hA5;

  assign bus.sdr_busy       = force_busy | (drv_cnt != 0);
  assign bus.sdr_data_ready = drv_ready;
  assign bus.sdr_dout       = drv_data;

  always @(posedge clk) begin
    drv_ready <= 1'b0;
    if (!resetn) drv_cnt <= 0;
    else if (drv_cnt != 0) begin
      drv_cnt <= drv_cnt - 1;
      if (drv_cnt == 1 && drv_is_rd) drv_ready <= 1'b1;
    end else if (bus.sdr_rd) begin
      drv_cnt   <= RD_LAT;
      drv_is_rd <= 1'b1;
    end else if (bus.sdr_wr || bus.sdr_refresh) begin
      drv_cnt   <= WR_LAT;
      drv_is_rd <= 1'b0;
    end
  end

  // event log
  int          cyc = 0;
  int          rw_kind[$];
  logic [22:0] rw_addr[$];
  logic [7:0]  rw_din[$];
  int          rw_cyc[$];
  int          rf_cyc[$];
  int          ack_port[$];
  int          ack_cyc[$];
  int          multi_ack = 0;
  int          multi_strobe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (int'(bus.sdr_rd) + int'(bus.sdr_wr) + int'(bus.sdr_refresh) > 1) multi_strobe++;
    if (bus.sdr_rd || bus.sdr_wr) begin
      rw_kind.push_back(bus.sdr_wr ? 2 : 1);
      rw_addr.push_back(bus.sdr_addr);
      rw_din.push_back(bus.sdr_din);
      rw_cyc.push_back(cyc);
    end
    if (bus.sdr_refresh) rf_cyc.push_back(cyc);
    for (int p = 0; p < NP; p++) begin
      if (bus.p_ack[p]) begin
        ack_port.push_back(p);
        ack_cyc.push_back(cyc);
      end
    end
    if ($countones(bus.p_ack) > 1) multi_ack++;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ack(input int port, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      if (bus.p_ack[port]) ok = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, ba, brf, t_req, t0, busy_cnt, n_between;
    bit ok;
    int exp_g[6];
    exp_g = '{2, 0, 1, 2, 0, 1};

    bus.p_rd   = '0;
    bus.p_wr   = '0;
    bus.p_addr = '0;
    bus.p_din  = '0;
    bus.rfsh   = 1'b0;
    resetn     = 1'b0;
    step_n(3);

    // reset values
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_strobes", 32'({bus.sdr_rd, bus.sdr_wr, bus.sdr_refresh}), 0);
    chk("rst_ack", 32'(bus.p_ack), 0);
    chk("rst_dout", 32'(bus.p_dout), 0);
    chk("rst_addr", 32'(bus.sdr_addr), 0);
    chk("rst_din", 32'(bus.sdr_din), 0);

    // INIT holds while the driver is busy
    resetn = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.busy) busy_cnt++;
    end
    chk("init_busy_cycles", busy_cnt, 10);
    chk("init_no_cmds", rw_kind.size() + rf_cyc.size(), 0);
    force_busy = 1'b0;
    step();
    chk("init_exit_busy", 32'(bus.busy), 0);

    // single read, port 1
    b  = rw_kind.size();
    ba = ack_port.size();
    bus.p_addr[1*AW +: AW] = 21'h00123;
    bus.p_rd[1] = 1'b1;
    t_req = cyc;
    wait_ack(1, 40, ok);
    chk("rd_ack_seen", 32'(ok), 1);
    chk("rd_dout", 32'(bus.p_dout[15:8]), 32'h A5);
    bus.p_rd[1] = 1'b0;
    step_n(5);
    chk("rd_cmd_count", rw_kind.size() - b, 1);
    if (rw_kind.size() > b) begin
      chk("rd_kind", rw_kind[b], 1);
      chk("rd_addr", 32'(rw_addr[b]), 32'h000123);
      chk("rd_req_to_strobe", rw_cyc[b] - t_req, 1);
      if (ack_cyc.size() > ba) chk("rd_strobe_to_ack", ack_cyc[ba] - rw_cyc[b], RD_LAT + 2);
    end
    chk("rd_ack_count", ack_port.size() - ba, 1);
    if (ack_port.size() > ba) chk("rd_ack_port", ack_port[ba], 1);
    chk("rd_dout_hold", 32'(bus.p_dout[15:8]), 32'h A5);
    chk("rd_other_dout", 32'({bus.p_dout[23:16], bus.p_dout[7:0]}), 0);

    // all three ports writing continuously; last grant was port 1
    b  = rw_kind.size();
    ba = ack_port.size();
    for (int p = 0; p < NP; p++) begin
      bus.p_addr[p*AW +: AW] = AW'(32'h1000 + 32'h111 * p);
      bus.p_din[p*8 +: 8]    = 8'(8'h10 + 8'h11 * p);
    end
    bus.p_wr = 3'b111;
    for (int i = 0; i < 300 && (ack_port.size() - ba) < 6; i++) step();
    bus.p_wr = '0;
    step_n(20);
    chk("wr_rr_acks_seen", (ack_port.size() - ba >= 6) ? 1 : 0, 1);
    chk("wr_rr_cmd_count", rw_kind.size() - b, 6);
    for (int k = 0; k < 6; k++) begin
      if (rw_kind.size() > b + k) begin
        chk($sformatf("wr_kind%0d", k), rw_kind[b+k], 2);
        chk($sformatf("wr_din%0d", k), 32'(rw_din[b+k]), 32'h10 + 32'h11 * exp_g[k]);
        chk($sformatf("wr_addr%0d", k), 32'(rw_addr[b+k]), 32'h1000 + 32'h111 * exp_g[k]);
      end
      if (ack_port.size() > ba + k) chk($sformatf("wr_grant%0d", k), ack_port[ba+k], exp_g[k]);
    end
`ifndef SDRAM_AUTO_REFRESH_EN
    if (rw_cyc.size() > b + 1) chk("wr_strobe_gap", rw_cyc[b+1] - rw_cyc[b], 5);
`endif
    chk("wr_no_double_ack", multi_ack, 0);

    // read and write together on port 0: write wins
    b  = rw_kind.size();
    ba = ack_port.size();
    bus.p_addr[0*AW +: AW] = 21'h0ABCD;
    bus.p_din[7:0] = 8'h3C;
    bus.p_rd[0] = 1'b1;
    bus.p_wr[0] = 1'b1;
    wait_ack(0, 40, ok);
    chk("rdwr_ack_seen", 32'(ok), 1);
    bus.p_rd[0] = 1'b0;
    bus.p_wr[0] = 1'b0;
    step_n(5);
    chk("rdwr_cmd_count", rw_kind.size() - b, 1);
    if (rw_kind.size() > b) begin
      chk("rdwr_kind", rw_kind[b], 2);
      chk("rdwr_din", 32'(rw_din[b]), 32'h3C);
    end

    // refresh requested twice during port 2 read, port 0 waiting
    b   = rw_kind.size();
    ba  = ack_port.size();
    brf = rf_cyc.size();
    bus.p_addr[2*AW +: AW] = 21'h1ABCD;
    bus.p_addr[0*AW +: AW] = 21'h00777;
    bus.p_rd[2] = 1'b1;
    for (int i = 0; i < 20 && rw_kind.size() == b; i++) step();
    chk("mix_rd2_issued", rw_kind.size() - b, 1);
    bus.p_rd[0] = 1'b1;
    bus.rfsh = 1'b1;
    step();
    bus.rfsh = 1'b0;
    step();
    bus.rfsh = 1'b1;
    step();
    bus.rfsh = 1'b0;
    for (int i = 0; i < 200 && (ack_port.size() - ba) < 2; i++) begin
      step();
      for (int p = 0; p < NP; p++) if (bus.p_ack[p]) bus.p_rd[p] = 1'b0;
    end
    step_n(10);
    chk("mix_ack_count", ack_port.size() - ba, 2);
    if (ack_port.size() > ba + 1) begin
      chk("mix_ack_first", ack_port[ba], 2);
      chk("mix_ack_second", ack_port[ba+1], 0);
    end
    chk("mix_rw_count", rw_kind.size() - b, 2);
    if (rw_kind.size() > b + 1) begin
      chk("mix_addr_first", 32'(rw_addr[b]), 32'h1ABCD);
      chk("mix_addr_second", 32'(rw_addr[b+1]), 32'h00777);
      n_between = 0;
      for (int i = brf; i < rf_cyc.size(); i++)
        if (rf_cyc[i] > rw_cyc[b] && rf_cyc[i] < rw_cyc[b+1]) n_between++;
`ifdef SDRAM_AUTO_REFRESH_EN
      chk("mix_rf_between", (n_between >= 1) ? 1 : 0, 1);
`else
      chk("mix_rf_between", n_between, 1);
      chk("mix_rf_total", rf_cyc.size() - brf, 1);
`endif
    end
    chk("mix_no_multi_strobe", multi_strobe, 0);

    // reset while a write is in flight
    bus.p_addr[1*AW +: AW] = 21'h01F00;
    bus.p_din[15:8] = 8'h77;
    bus.p_wr[1] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (bus.sdr_wr) ok = 1'b1;
    end
    chk("rstw_wr_seen", 32'(ok), 1);
    resetn = 1'b0;
    #1;
    chk("rstw_sdr_wr", 32'(bus.sdr_wr), 0);
    chk("rstw_busy", 32'(bus.busy), 1);
    chk("rstw_addr", 32'(bus.sdr_addr), 0);
    chk("rstw_din", 32'(bus.sdr_din), 0);
    chk("rstw_dout", 32'(bus.p_dout), 0);
    bus.p_wr = '0;
    step_n(2);
    ba  = ack_port.size();
    brf = rf_cyc.size();
    resetn = 1'b1;
    t0 = cyc;
    step_n(70);
    chk("rstw_no_ack", ack_port.size() - ba, 0);
`ifdef SDRAM_AUTO_REFRESH_EN
    chk("auto_rf_count", (rf_cyc.size() - brf >= 4) ? 1 : 0, 1);
    if (rf_cyc.size() - brf >= 4) begin
      chk("auto_rf_first", rf_cyc[brf] - t0, RI + 1);
      for (int k = 0; k < 3; k++)
        chk($sformatf("auto_rf_gap%0d", k), rf_cyc[brf+k+1] - rf_cyc[brf+k], RI);
    end
`else
    chk("idle_no_refresh", rf_cyc.size() - brf, 0);
    chk("idle_busy", 32'(bus.busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
